spi_master: RTL and testbench

Single-master SPI initiator that issues 10-bit command frames to the on-chip SPI slave/RAM subsystem and captures 8-bit read data returned on MISO. Sits between a host-side command interface (register bank or test sequencer) and the SPI pins. It runs on the same clk as the slave, shifting one bit per clk. It generates SS_n framing, MOSI serialisation, the read turnaround and MISO capture.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_shifter.sv | 43 ++++
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, frame widths and the FSM state
// encoding common to the master and the slave/RAM subsystem.
package spi_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_CMD   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_TURN  = 3'd5;
    localparam logic [2:0] ST_RECV  = 3'd6;
    localparam logic [2:0] ST_END   = 3'd7;

endpackage

// File: rtl/spi_master_shifter.sv
// Loadable 10-bit PISO driving MOSI and an 8-bit SIPO capturing MISO.
// MOSI is registered and forced low whenever tx_en is deasserted.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               tx_en,
    input  logic               tx_shift,
    input  logic               rx_en,
    input  logic               miso,
    output logic               mosi,
    output logic [DATA_W-1:0]  rx_next
);

    logic [FRAME_W-1:0] tx_sr;
    logic [DATA_W-2:0]  rx_sr;

    // rx_next already contains the bit sampled on this edge, so the top can
    // publish the complete byte on the same edge as the final sample.
    assign rx_next = {rx_sr, miso};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_sr <= '0;
            rx_sr <= '0;
            mosi  <= 1'b0;
        end else begin
            if (load) begin
                tx_sr <= frame;
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            end
            mosi <= tx_en ? tx_sr[FRAME_W-1] : 1'b0;
            if (rx_en) begin
                rx_sr <= rx_next[DATA_W-2:0];
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator issuing 10-bit command frames and capturing 8-bit read data.
// Optional read-sequence check enabled by defining SPI_MASTER_SEQ_CHECK_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TA_CYC  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] cmd_in,
    output logic               busy,
    output logic               done,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               err,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    // Handshake: a command is taken on a posedge with start=1 while busy=0;
    // start during busy is ignored and cmd_in is not sampled again.
    logic [2:0]        state, next_state;
    logic [3:0]        cnt, cnt_next;
    logic [1:0]        code;
    logic              accept;
    logic              block_rd;
    logic [DATA_W-1:0] rx_next;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic addr_ok;

    assign block_rd = (cmd_in[9:8] == CMD_RD_DATA) && !addr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_ok <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= (state == ST_IDLE) && start && block_rd;
            if (next_state == ST_END && code == CMD_RD_ADDR) begin
                addr_ok <= 1'b1;
            end else if (next_state == ST_END && code == CMD_RD_DATA) begin
                addr_ok <= 1'b0;
            end
        end
    end
`else
    assign block_rd = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !block_rd) begin
                    accept     = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: next_state = ST_CMD;
            ST_CMD: begin
                next_state = ST_SHIFT;
                cnt_next   = 4'd9;
            end
            ST_SHIFT: begin
                if (cnt == 4'd0) begin
                    if (code == CMD_RD_DATA) begin
                        next_state = ST_TURN;
                        cnt_next   = 4'(TA_CYC - 1);
                    end else begin
                        next_state = ST_GAP;
                        cnt_next   = 4'(GAP_CYC - 1);
                    end
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 4'd0) next_state = ST_END;
                else             cnt_next   = cnt - 4'd1;
            end
            ST_TURN: begin
                if (cnt == 4'd0) begin
                    next_state = ST_RECV;
                    cnt_next   = 4'(DATA_W - 1);
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RECV: begin
                if (cnt == 4'd0) next_state = ST_END;
                else             cnt_next   = cnt - 4'd1;
            end
            ST_END:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so each reflects the state it
    // belongs to during that state's own cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            code     <= '0;
            SS_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (accept) begin
                code <= cmd_in[9:8];
            end
            SS_n     <= (next_state == ST_IDLE) || (next_state == ST_END);
            busy     <= (next_state != ST_IDLE);
            done     <= (next_state == ST_END);
            rd_valid <= (next_state == ST_END) && (code == CMD_RD_DATA);
            if (next_state == ST_END && code == CMD_RD_DATA) begin
                rd_data <= rx_next;
            end
        end
    end

    spi_master_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .frame    (cmd_in),
        .tx_en    ((next_state == ST_CMD) || (next_state == ST_SHIFT)),
        .tx_shift (next_state == ST_SHIFT),
        .rx_en    (state == ST_RECV),
        .miso     (MISO),
        .mosi     (MOSI),
        .rx_next  (rx_next)
    );

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: frame timing, MOSI bit order, read capture,
// start-while-busy, mid-frame reset and the optional read-sequence check.
module tb_spi_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] cmd_in;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int total = 0;
    int bad   = 0;

    logic [0:0] exp_q[$];

    int   ss_low, done_cnt, done_cyc, busy_cnt, err_cnt, err_cyc;
    logic rdv_at_done;

    spi_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd_in   (cmd_in),
        .busy     (busy),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .err      (err),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        MISO  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One command from the accept edge through 30 cycles. Cycle c is the
    // interval after the c-th posedge following the accept edge.
    task automatic run_frame(input logic [9:0] cmd, input logic [7:0] miso_byte,
                             input bit hold_start, input bit expect_issue);
        logic [0:0] e;
        ss_low = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
        err_cnt = 0; err_cyc = 0; rdv_at_done = 1'b0;
        if (expect_issue) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(cmd[9]);
            for (int i = 9; i >= 0; i--) exp_q.push_back(cmd[i]);
        end
        @(negedge clk);
        start  = 1'b1;
        cmd_in = cmd;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!SS_n) ss_low++;
            if (busy) busy_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = c;
                rdv_at_done = rd_valid;
            end
            if (expect_issue && c <= 12) begin
                e = exp_q.pop_front();
                check($sformatf("mosi c%0d", c), 32'(MOSI), 32'(e));
            end
            start = hold_start && (c < 15);
            if (hold_start) cmd_in = 10'($urandom_range(0, 1023));
            MISO = (c >= 16 && c <= 23) ? miso_byte[23 - c] : 1'b0;
        end
        start = 1'b0;
        MISO  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_ss, input int exp_busy,
                               input logic exp_rdv);
        check({tag, " ss_low"},   32'(ss_low),      32'(exp_ss));
        check({tag, " done_cnt"}, 32'(done_cnt),    32'd1);
        check({tag, " done_cyc"}, 32'(done_cyc),    32'(exp_busy));
        check({tag, " busy_cnt"}, 32'(busy_cnt),    32'(exp_busy));
        check({tag, " rd_valid"}, 32'(rdv_at_done), 32'(exp_rdv));
        check({tag, " err_cnt"},  32'(err_cnt),     32'd0);
    endtask

    initial begin
        int dones;
        rst_n  = 1'b0;
        start  = 1'b0;
        cmd_in = '0;
        MISO   = 1'b0;
        do_reset();

        check("rst SS_n",     32'(SS_n),     32'd1);
        check("rst MOSI",     32'(MOSI),     32'd0);
        check("rst busy",     32'(busy),     32'd0);
        check("rst done",     32'(done),     32'd0);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst err",      32'(err),      32'd0);
        check("rst rd_data",  32'(rd_data),  32'h00);

        run_frame(10'b00_0010_1010, 8'h00, 1'b0, 1'b1);
        check_frame("wr_addr", 14, 15, 1'b0);

        run_frame(10'b10_0101_0101, 8'h00, 1'b0, 1'b1);
        check_frame("rd_addr", 14, 15, 1'b0);

        run_frame(10'b11_0000_0000, 8'hA5, 1'b0, 1'b1);
        check_frame("rd_data", 23, 24, 1'b1);
        check("rd_data value", 32'(rd_data), 32'hA5);

        run_frame(10'b01_1100_0011, 8'h00, 1'b1, 1'b1);
        check_frame("held_start", 14, 15, 1'b0);
        check("rd_data held", 32'(rd_data), 32'hA5);

        // reset during SHIFT bit 5 (cycle 7) of a write frame
        @(negedge clk);
        start  = 1'b1;
        cmd_in = 10'b00_1111_0000;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst SS_n",    32'(SS_n),    32'd1);
        check("midrst busy",    32'(busy),    32'd0);
        check("midrst done",    32'(done),    32'd0);
        check("midrst MOSI",    32'(MOSI),    32'd0);
        check("midrst rd_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst no_done", 32'(dones), 32'd0);

        run_frame(10'b01_0110_1001, 8'h00, 1'b0, 1'b1);
        check_frame("wr_after_rst", 14, 15, 1'b0);

        do_reset();
`ifdef SPI_MASTER_SEQ_CHECK_EN
        run_frame(10'b11_0000_0000, 8'h3C, 1'b0, 1'b0);
        check("seq err_cnt",  32'(err_cnt),  32'd1);
        check("seq err_cyc",  32'(err_cyc),  32'd1);
        check("seq ss_low",   32'(ss_low),   32'd0);
        check("seq busy_cnt", 32'(busy_cnt), 32'd0);
        check("seq done_cnt", 32'(done_cnt), 32'd0);
        check("seq rd_data",  32'(rd_data),  32'h00);
`else
        run_frame(10'b11_0000_0000, 8'h3C, 1'b0, 1'b1);
        check_frame("seq_off", 23, 24, 1'b1);
        check("seq_off rd_data", 32'(rd_data), 32'h3C);
`endif

        check("exp_q empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
